// File: rtl/mb_reconstruct_add_pkg.sv
// Shared types and constants for the macroblock reconstruction stage.
package mb_reconstruct_add_pkg;

  typedef enum logic [1:0] {
    RECON_IDLE  = 2'd0,
    RECON_ISSUE = 2'd1,
    RECON_DRAIN = 2'd2
  } recon_state_t;

  localparam int unsigned PIX_PER_BLOCK = 64;
  localparam int unsigned RD_CNT_W      = 9;
  localparam int unsigned PRED_ADDR_W   = 11;
  localparam int unsigned PRED_BANK_BIT = 10;
  localparam int unsigned PIX_W         = 8;
  localparam int unsigned BLK_W         = 3;
  localparam int unsigned IDX_W         = 6;
  localparam int unsigned SUM_W         = 11;

  localparam logic signed [SUM_W-1:0] SAT_LO = 11'sd0;
  localparam logic signed [SUM_W-1:0] SAT_HI = 11'sd255;

  typedef struct packed {
    logic [PIX_W-1:0] pixel;
    logic [BLK_W-1:0] block;
    logic [IDX_W-1:0] index;
  } pix_entry_t;

  // Clamp a signed prediction+residual sum into the 8-bit pixel range.
  function automatic logic [PIX_W-1:0] saturate_pixel(input logic signed [SUM_W-1:0] sum);
    if (sum < SAT_LO) return PIX_W'(SAT_LO);
    if (sum > SAT_HI) return PIX_W'(SAT_HI);
    return sum[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/mb_reconstruct_add_fifo.sv
// recon_out_fifo: synchronous FIFO with same-cycle push/pop (even when full) and occupancy count.
module recon_out_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 17
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_next;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (pop && !push) count_next = count - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      valid <= (count_next != '0);
    end
  end

  // Entries are cleared on reset so the head reads zero while empty.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    always_ff @(posedge clock) begin
      if (reset)                            mem[g] <= '0;
      else if (push && (wr_ptr == AW'(g)))  mem[g] <= push_data;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/mb_reconstruct_add.sv
// Macroblock reconstruction: prediction + residual, saturated, streamed out over valid/ready.
// Optional running pixel checksum port enabled by RECON_CHECKSUM_EN.
module mb_reconstruct_add
  import mb_reconstruct_add_pkg::*;
#(
  parameter int unsigned BLOCKS_PER_MB = 6,
  parameter int unsigned RESID_W       = 9,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     Start_Recon_I,
  input  logic                     Pred_Bank_I,
  input  logic [BLOCKS_PER_MB-1:0] Coded_Block_Pattern_I,
  input  logic                     Intra_MB_I,
  output logic [PRED_ADDR_W-1:0]   Pred_Addr_O,
  input  logic [PIX_W-1:0]         Pred_Data_I,
  output logic [RD_CNT_W-1:0]      Resid_Addr_O,
  output logic                     Resid_Rd_O,
  input  logic [RESID_W-1:0]       Resid_Data_I,
  output logic [PIX_W-1:0]         Pix_Data_O,
  output logic [BLK_W-1:0]         Pix_Block_O,
  output logic [IDX_W-1:0]         Pix_Index_O,
  output logic                     Pix_Valid_O,
  input  logic                     Pix_Ready_I,
`ifdef RECON_CHECKSUM_EN
  output logic [15:0]              Checksum_O,
`endif
  output logic                     Done_Recon_O
);

  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CRED_W = FCNT_W + 1;
  localparam logic [RD_CNT_W-1:0] LAST_RD = RD_CNT_W'(BLOCKS_PER_MB * PIX_PER_BLOCK - 1);

  recon_state_t state, state_next;

  logic [RD_CNT_W-1:0]      rd_cnt;
  logic [RD_CNT_W-1:0]      issue_addr_c;
  logic [PRED_ADDR_W-1:0]   pred_addr_c;
  logic [BLOCKS_PER_MB-1:0] cbp_q, cbp_c;
  logic                     bank_q, bank_c, intra_q;
  logic                     start_c, issue_c, coded_c, credit_c, fifo_empty_next_c;
  logic [CRED_W-1:0]        used_c;

  logic                     rd_v, dat_v, dat_coded;
  logic [RD_CNT_W-1:0]      dat_addr;

  logic [PIX_W-1:0]         pred_c;
  logic signed [SUM_W-1:0]  pred_ext, resid_ext;
  pix_entry_t               push_entry, head;
  logic                     pop;
  logic [FCNT_W-1:0]        fifo_count;

  assign pop = Pix_Valid_O && Pix_Ready_I;

  // Credit covers the read being presented and the one whose data is landing now.
  assign used_c   = CRED_W'(fifo_count) + CRED_W'(rd_v) + CRED_W'(dat_v);
  assign credit_c = used_c < CRED_W'(FIFO_DEPTH);
  assign fifo_empty_next_c = (fifo_count == '0) || ((fifo_count == FCNT_W'(1)) && pop);

  // Next state and the read decision for the following cycle.
  always_comb begin
    state_next   = state;
    start_c      = 1'b0;
    issue_c      = 1'b0;
    issue_addr_c = rd_cnt;
    bank_c       = bank_q;
    cbp_c        = cbp_q;
    case (state)
      RECON_IDLE: begin
        if (Start_Recon_I) begin
          start_c      = 1'b1;
          issue_c      = 1'b1;
          issue_addr_c = '0;
          bank_c       = Pred_Bank_I;
          cbp_c        = Coded_Block_Pattern_I;
          state_next   = RECON_ISSUE;
        end
      end
      RECON_ISSUE: begin
        if (credit_c) begin
          issue_c = 1'b1;
          if (rd_cnt == LAST_RD) state_next = RECON_DRAIN;
        end
      end
      RECON_DRAIN: begin
        if (!rd_v && !dat_v && fifo_empty_next_c) state_next = RECON_IDLE;
      end
      default: state_next = RECON_IDLE;
    endcase
    coded_c     = cbp_c[issue_addr_c[RD_CNT_W-1 -: BLK_W]];
    pred_addr_c = PRED_ADDR_W'(issue_addr_c);
    pred_addr_c[PRED_BANK_BIT] = bank_c;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RECON_IDLE;
      rd_cnt       <= '0;
      bank_q       <= 1'b0;
      cbp_q        <= '0;
      intra_q      <= 1'b0;
      rd_v         <= 1'b0;
      dat_v        <= 1'b0;
      dat_addr     <= '0;
      dat_coded    <= 1'b0;
      Pred_Addr_O  <= '0;
      Resid_Addr_O <= '0;
      Resid_Rd_O   <= 1'b0;
      Done_Recon_O <= 1'b1;
    end else begin
      state        <= state_next;
      Done_Recon_O <= (state_next == RECON_IDLE);
      if (start_c) begin
        bank_q  <= Pred_Bank_I;
        cbp_q   <= Coded_Block_Pattern_I;
        intra_q <= Intra_MB_I;
      end
      rd_v       <= issue_c;
      Resid_Rd_O <= issue_c && coded_c;
      if (issue_c) begin
        Pred_Addr_O  <= pred_addr_c;
        Resid_Addr_O <= issue_addr_c;
        rd_cnt       <= issue_addr_c + RD_CNT_W'(1);
      end
      dat_v     <= rd_v;
      dat_addr  <= Resid_Addr_O;
      dat_coded <= Resid_Rd_O;
    end
  end

  // Read data lands one cycle after its address; uncoded blocks ignore the residual bus.
  always_comb begin
    pred_c           = intra_q ? '0 : Pred_Data_I;
    pred_ext         = SUM_W'(pred_c);
    resid_ext        = dat_coded ? SUM_W'($signed(Resid_Data_I)) : '0;
    push_entry.pixel = saturate_pixel(pred_ext + resid_ext);
    push_entry.block = dat_addr[RD_CNT_W-1 -: BLK_W];
    push_entry.index = dat_addr[IDX_W-1:0];
  end

  recon_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pix_entry_t))
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (dat_v),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .valid     (Pix_Valid_O),
    .count     (fifo_count)
  );

  assign Pix_Data_O  = head.pixel;
  assign Pix_Block_O = head.block;
  assign Pix_Index_O = head.index;

`ifdef RECON_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset || start_c) Checksum_O <= '0;
    else if (pop)         Checksum_O <= Checksum_O + 16'(Pix_Data_O);
  end
`endif

endmodule

// File: tb/tb_mb_reconstruct_add.sv
// Self-checking bench for mb_reconstruct_add: reference model, saturation table, corner sequences.
module tb_mb_reconstruct_add;

  logic       clock = 1'b0;
  logic       reset;
  logic       Start_Recon_I, Pred_Bank_I, Intra_MB_I, Pix_Ready_I;
  logic [5:0] Coded_Block_Pattern_I;
  logic [10:0] Pred_Addr_O;
  logic [7:0] Pred_Data_I;
  logic [8:0] Resid_Addr_O;
  logic       Resid_Rd_O;
  logic [8:0] Resid_Data_I;
  logic [7:0] Pix_Data_O;
  logic [2:0] Pix_Block_O;
  logic [5:0] Pix_Index_O;
  logic       Pix_Valid_O, Done_Recon_O;
`ifdef RECON_CHECKSUM_EN
  logic [15:0] Checksum_O;
`endif

  mb_reconstruct_add dut (
    .clock                 (clock),
    .reset                 (reset),
    .Start_Recon_I         (Start_Recon_I),
    .Pred_Bank_I           (Pred_Bank_I),
    .Coded_Block_Pattern_I (Coded_Block_Pattern_I),
    .Intra_MB_I            (Intra_MB_I),
    .Pred_Addr_O           (Pred_Addr_O),
    .Pred_Data_I           (Pred_Data_I),
    .Resid_Addr_O          (Resid_Addr_O),
    .Resid_Rd_O            (Resid_Rd_O),
    .Resid_Data_I          (Resid_Data_I),
    .Pix_Data_O            (Pix_Data_O),
    .Pix_Block_O           (Pix_Block_O),
    .Pix_Index_O           (Pix_Index_O),
    .Pix_Valid_O           (Pix_Valid_O),
    .Pix_Ready_I           (Pix_Ready_I),
`ifdef RECON_CHECKSUM_EN
    .Checksum_O            (Checksum_O),
`endif
    .Done_Recon_O          (Done_Recon_O)
  );

  always #5 clock = ~clock;

  int pred_mem  [2048];
  int resid_mem [512];
  int got_pix   [384];
  int tests = 0;
  int fails = 0;

  // Buffer models: one-cycle read latency; the residual bus carries junk when not strobed.
  always @(posedge clock) begin
    Pred_Data_I <= 8'(pred_mem[Pred_Addr_O]);
    if (Resid_Rd_O) Resid_Data_I <= 9'(resid_mem[Resid_Addr_O]);
    else            Resid_Data_I <= 9'($urandom);
  end

  typedef struct {int pix; int blk; int idx;} pix_t;
  typedef struct {int pred; int resid; int exp;} sat_vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int recon(int pred, int resid, bit coded, bit intra);
    int s;
    s = (intra ? 0 : pred) + (coded ? resid : 0);
    if (s < 0)   return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic fill_const(input int p, input int r);
    for (int i = 0; i < 2048; i++) pred_mem[i] = p;
    for (int i = 0; i < 512; i++)  resid_mem[i] = r;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 2048; i++) pred_mem[i] = int'($urandom_range(255));
    for (int i = 0; i < 512; i++)  resid_mem[i] = int'($urandom_range(511)) - 256;
  endtask

  task automatic run_mb(input logic bank, input logic [5:0] cbp, input logic intra,
                        input int ready_pct, input int reset_at, input bit extra_start);
    pix_t exp_q[$];
    int   exp_sum, n_out, first_valid, done_at, rd_pulses, bad_rd, bad_bank, bad_idle;
    bit   prev_stall, finished;
    logic [16:0] held;
    exp_sum = 0;
    for (int b = 0; b < 6; b++)
      for (int i = 0; i < 64; i++) begin
        pix_t e;
        e.pix = recon(pred_mem[(bank ? 1024 : 0) + b*64 + i], resid_mem[b*64 + i], cbp[b], intra);
        e.blk = b;
        e.idx = i;
        exp_q.push_back(e);
        exp_sum += e.pix;
      end
    n_out = 0; first_valid = -1; done_at = -1; rd_pulses = 0; bad_rd = 0; bad_bank = 0;
    prev_stall = 0; finished = 0; held = '0;

    @(negedge clock);
    Pred_Bank_I = bank; Coded_Block_Pattern_I = cbp; Intra_MB_I = intra;
    Start_Recon_I = 1'b1;
    Pix_Ready_I = (ready_pct >= 100) || ($urandom_range(99) < ready_pct);

    for (int rel = 1; rel <= 3000 && !finished; rel++) begin
      @(negedge clock);
      Start_Recon_I = extra_start && (rel == 50);
      if (extra_start && rel == 50) begin
        Pred_Bank_I = ~bank; Coded_Block_Pattern_I = ~cbp; Intra_MB_I = ~intra;
      end
      Pix_Ready_I = (ready_pct >= 100) || ($urandom_range(99) < ready_pct);

      if (Pix_Valid_O && first_valid < 0) first_valid = rel;
      if (prev_stall)
        check($sformatf("stall_hold_%0d", n_out), {Pix_Valid_O, Pix_Data_O, Pix_Block_O, Pix_Index_O},
              {1'b1, held});
      if (Resid_Rd_O) begin
        rd_pulses++;
        if (!cbp[Resid_Addr_O[8:6]]) bad_rd++;
      end
      if (!Done_Recon_O && Pred_Addr_O[10] !== bank) bad_bank++;
      if (Pix_Valid_O && Pix_Ready_I) begin
        if (n_out < 384) begin
          check($sformatf("pix_%0d", n_out), {Pix_Data_O, Pix_Block_O, Pix_Index_O},
                {8'(exp_q[n_out].pix), 3'(exp_q[n_out].blk), 6'(exp_q[n_out].idx)});
          got_pix[n_out] = int'(Pix_Data_O);
        end else begin
          check("extra_pixel", 32'(n_out), 32'd383);
        end
        n_out++;
      end
      prev_stall = Pix_Valid_O && !Pix_Ready_I;
      held = {Pix_Data_O, Pix_Block_O, Pix_Index_O};

      if (reset_at >= 0 && n_out == reset_at) begin
        reset = 1'b1; Pix_Ready_I = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("reset_valid", 32'(Pix_Valid_O), 32'd0);
        check("reset_done", 32'(Done_Recon_O), 32'd1);
`ifdef RECON_CHECKSUM_EN
        check("reset_checksum", 32'(Checksum_O), 32'd0);
`endif
        bad_idle = 0;
        repeat (4) begin
          @(negedge clock);
          if (Pix_Valid_O || Resid_Rd_O || !Done_Recon_O) bad_idle++;
        end
        check("reset_idle", 32'(bad_idle), 32'd0);
        return;
      end
      if (Done_Recon_O) begin
        done_at = rel;
        finished = 1;
      end
    end

    check("done_reached", 32'(finished), 32'd1);
    check("pixel_count", 32'(n_out), 32'd384);
    check("resid_rd_pulses", 32'(rd_pulses), 32'(64 * $countones(cbp)));
    check("resid_rd_uncoded", 32'(bad_rd), 32'd0);
    check("pred_bank_bit", 32'(bad_bank), 32'd0);
    if (ready_pct >= 100) begin
      check("first_valid_cycle", 32'(first_valid), 32'd3);
      check("done_cycle", 32'(done_at), 32'd387);
    end
`ifdef RECON_CHECKSUM_EN
    check("checksum", 32'(Checksum_O), 32'(exp_sum % 65536));
`endif
  endtask

  initial begin
    sat_vec_t sat_tab[8];
    int bad;
    sat_tab = '{'{250, 10, 255}, '{5, -10, 0}, '{0, -256, 0}, '{255, 255, 255},
                '{100, 20, 120}, '{128, -128, 0}, '{0, 255, 255}, '{200, -1, 199}};

    reset = 1'b1; Start_Recon_I = 0; Pred_Bank_I = 0; Intra_MB_I = 0;
    Coded_Block_Pattern_I = '0; Pix_Ready_I = 0;
    fill_const(0, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_valid", 32'(Pix_Valid_O), 32'd0);
    check("rst_resid_rd", 32'(Resid_Rd_O), 32'd0);
    check("rst_data", 32'(Pix_Data_O), 32'd0);
    check("rst_block", 32'(Pix_Block_O), 32'd0);
    check("rst_index", 32'(Pix_Index_O), 32'd0);
    check("rst_pred_addr", 32'(Pred_Addr_O), 32'd0);
    check("rst_resid_addr", 32'(Resid_Addr_O), 32'd0);
    check("rst_done", 32'(Done_Recon_O), 32'd1);

    // Flat prediction + residual, full throughput.
    fill_const(100, 20);
    run_mb(1'b0, 6'h3F, 1'b0, 100, -1, 0);
    bad = 0;
    for (int i = 0; i < 384; i++) if (got_pix[i] != 120) bad++;
    check("all_120", 32'(bad), 32'd0);
`ifdef RECON_CHECKSUM_EN
    check("checksum_46080", 32'(Checksum_O), 32'd46080);
`endif

    // Saturation table in the first pixels of block 0.
    fill_random();
    foreach (sat_tab[i]) begin
      pred_mem[i]  = sat_tab[i].pred;
      resid_mem[i] = sat_tab[i].resid;
    end
    run_mb(1'b0, 6'h3F, 1'b0, 100, -1, 0);
    foreach (sat_tab[i]) check($sformatf("sat_%0d", i), 32'(got_pix[i]), 32'(sat_tab[i].exp));

    // Partial coded-block pattern: uncoded blocks pass the prediction through.
    fill_random();
    run_mb(1'b0, 6'b000101, 1'b0, 100, -1, 0);
    bad = 0;
    for (int i = 0; i < 384; i++)
      if ((i / 64) inside {1, 3, 4, 5} && got_pix[i] != pred_mem[i]) bad++;
    check("uncoded_passthru", 32'(bad), 32'd0);

    // Intra from bank 1.
    fill_const(77, 33);
    run_mb(1'b1, 6'h3F, 1'b1, 100, -1, 0);
    bad = 0;
    for (int i = 0; i < 384; i++) if (got_pix[i] != 33) bad++;
    check("intra_all_33", 32'(bad), 32'd0);

    // Random backpressure with an ignored second start.
    fill_random();
    run_mb(1'b0, 6'($urandom), 1'b0, 50, -1, 1);
    fill_random();
    run_mb(1'b1, 6'($urandom), 1'($urandom), 50, -1, 0);

    // Reset mid-macroblock, then a clean macroblock.
    fill_random();
    run_mb(1'b0, 6'h3F, 1'b0, 50, 100, 0);
    fill_random();
    run_mb(1'b1, 6'($urandom), 1'b0, 100, -1, 0);
    run_mb(1'b0, 6'h2A, 1'b0, 70, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
